conv_stream_sequencer: RTL and testbench
========================================

// Module: conv_stream_sequencer
// PURPOSE
//  Sequences one n x n feature-map frame through the convolver: latches kernel/BN config on start,
//  clears the line buffer, and gates conv_en per accepted pixel. Tracks row/col to flag legal
//  k x k window positions for stride s, and captures conv_out into a valid/ready output stage.
//  Sits between the activation stream source and the next layer; the convolver is its only datapath.
// PARAMETERS
//  N  16   data width (activation, weight element, output)
//  n  416  frame width = height in pixels
//  k  3    kernel size
//  s  1    stride (>=1)
// PORTS
//  clk         in   1      clock
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      begin frame; sampled only in IDLE
//  cfg_weight  in   k*k*N  kernel, latched on accepted start
//  cfg_gamma   in   N      BN gamma, latched on accepted start
//  cfg_beta    in   N      BN beta, latched on accepted start
//  s_valid     in   1      upstream pixel valid
//  s_ready     out  1      upstream pixel ready
//  s_data      in   N      upstream pixel, raster order
//  conv_rst    out  1      to convolver rst (active-high, sync)
//  conv_en     out  1      to convolver en; = s_valid & s_ready
//  conv_act    out  N      to convolver activation_in; = s_data
//  conv_weight out  k*k*N  latched kernel
//  conv_gamma  out  N      latched gamma
//  conv_beta   out  N      latched beta
//  conv_out    in   N      convolver result (combinational off its line buffer)
//  m_valid     out  1      output word valid
//  m_ready     in   1      downstream ready
//  m_data      out  N      output word
//  busy        out  1      state != IDLE
//  done        out  1      one-cycle pulse, frame complete
// BEHAVIOUR
//  Reset: state=IDLE; row,col,out_cnt,pend=0; m_valid=0; m_data=0; done=0; conv_rst=0; cfg regs=0.
//  FSM: IDLE -start-> FLUSH (cfg latched) -1 cycle, conv_rst=1-> STREAM
//       STREAM -last pixel (row=n-1,col=n-1) accepted-> DRAIN; DRAIN -pend=0 & out handshake done-> DONE
//       DONE -1 cycle, done=1-> IDLE. start outside IDLE ignored.
//  Position: col++ on accept; at n-1 wraps to 0 and row++. Window-valid pixel:
//   row>=k-1 & col>=k-1 & (row-(k-1))%s==0 & (col-(k-1))%s==0. Use step counters, not modulo.
//  pend: set by accept of window-valid pixel; conv_out is valid the following cycle. Stays stable
//   while conv_en=0.
//  out_free = !m_valid | m_ready. Capture: pend & out_free -> m_data<=conv_out, m_valid<=1, pend<=0,
//   out_cnt++. Same-cycle re-set of pend by a new accept has priority over clear.
//  s_ready = (state==STREAM) & (!pend | out_free). No pixel is accepted while an uncaptured result
//   would be overwritten by a line-buffer shift.
//  m_valid clears on m_ready unless reloaded the same cycle. m_data holds while m_valid & !m_ready.
//  Outputs per frame: O*O, O = (n-k)/s + 1 (integer division). DRAIN exits only after out_cnt==O*O
//   and the final word has handshaked.
//  Async reset mid-frame aborts the frame: no done. The next start re-flushes the line buffer.
//  No arithmetic here beyond counters. Counter widths: $clog2(n) for row/col, $clog2(O*O+1) for out_cnt.
// STRUCTURE
//  conv_pkg: state enum {IDLE,FLUSH,STREAM,DRAIN,DONE}; function out_dim(n,k,s).
//  One sub-module: conv_pos_tracker (row/col counters + stride phase counters -> win_valid, last_px).
//  Instantiates nothing else; the convolver is connected at the parent level.
// TESTING
//  n=5,k=3,s=1, ramp pixels 1..25, m_ready=1 -> exactly 9 m_valid beats, done pulse 1 cycle after the last.
//  n=5,k=3,s=2 -> 4 outputs, taken at (row,col)=(2,2),(2,4),(4,2),(4,4); out_cnt=4 at done.
//  s=1, m_ready=0 for 10 cycles after the 1st output -> s_ready drops after 1 pending result;
//   m_data stable; no loss; 9 total.
//  Random s_valid gaps (50%) + random m_ready -> output sequence matches golden model, order kept.
//  Assert rst_n low mid-STREAM -> all outputs at reset values immediately; restart gives a correct 9-output frame.
//  start pulsed during STREAM -> ignored; cfg_weight change mid-frame does not alter conv_weight.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution stream sequencer.
package conv_pkg;

    typedef enum logic [2:0] {IDLE, FLUSH, STREAM, DRAIN, DONE} state_t;

    // Window positions per axis for an n-wide frame, k-wide kernel, stride s.
    function automatic int out_dim(input int n, input int k, input int s);
        return (n - k) / s + 1;
    endfunction

endpackage

// File: rtl/conv_pos_tracker.sv
// Raster row/col tracker; flags pixels that complete a legal k x k window at stride s.
module conv_pos_tracker
    import conv_pkg::*;
#(
    parameter int n = 416,
    parameter int k = 3,
    parameter int s = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic adv,
    output logic win_valid,
    output logic last_px
);

    localparam int RW = $clog2(n);
    localparam int PW = (s > 1) ? $clog2(s) : 1;

    logic [RW-1:0] row;
    logic [RW-1:0] col;
    logic [PW-1:0] row_ph;
    logic [PW-1:0] col_ph;
    logic          col_end;
    logic          row_end;

    assign col_end = (col == RW'(n - 1));
    assign row_end = (row == RW'(n - 1));

    // Phase counters restart at k-1 so phase 0 marks every s-th position after it.
    function automatic logic [PW-1:0] step(input logic [PW-1:0] ph);
        return (ph == PW'(s - 1)) ? '0 : ph + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row    <= '0;
            col    <= '0;
            row_ph <= '0;
            col_ph <= '0;
        end else if (clr) begin
            row    <= '0;
            col    <= '0;
            row_ph <= '0;
            col_ph <= '0;
        end else if (adv) begin
            if (col_end) begin
                col    <= '0;
                col_ph <= '0;
                if (row_end) begin
                    row    <= '0;
                    row_ph <= '0;
                end else begin
                    row    <= row + RW'(1);
                    row_ph <= (row >= RW'(k - 1)) ? step(row_ph) : '0;
                end
            end else begin
                col    <= col + RW'(1);
                col_ph <= (col >= RW'(k - 1)) ? step(col_ph) : '0;
            end
        end
    end

    assign win_valid = (row >= RW'(k - 1)) && (col >= RW'(k - 1)) &&
                       (row_ph == '0) && (col_ph == '0);
    assign last_px   = row_end && col_end;

endmodule

// File: rtl/conv_stream_sequencer.sv
// Frame sequencer around the convolver: config latch, line-buffer flush, per-pixel
// enable and a single-word valid/ready output stage.
module conv_stream_sequencer
    import conv_pkg::*;
#(
    parameter int N = 16,
    parameter int n = 416,
    parameter int k = 3,
    parameter int s = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [k*k*N-1:0] cfg_weight,
    input  logic [N-1:0]     cfg_gamma,
    input  logic [N-1:0]     cfg_beta,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [N-1:0]     s_data,
    output logic             conv_rst,
    output logic             conv_en,
    output logic [N-1:0]     conv_act,
    output logic [k*k*N-1:0] conv_weight,
    output logic [N-1:0]     conv_gamma,
    output logic [N-1:0]     conv_beta,
    input  logic [N-1:0]     conv_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [N-1:0]     m_data,
    output logic             busy,
    output logic             done
);

    localparam int O  = out_dim(n, k, s);
    localparam int OO = O * O;
    localparam int CW = $clog2(OO + 1);

    state_t        state;
    state_t        state_nx;
    logic          pend;
    logic [CW-1:0] out_cnt;
    logic          win_valid;
    logic          last_px;
    logic          accept;
    logic          out_free;
    logic          capture;

    assign out_free = !m_valid || m_ready;
    assign capture  = pend && out_free;
    // Hold off the line buffer while a result it would overwrite is still uncaptured.
    assign s_ready  = (state == STREAM) && (!pend || out_free);
    assign accept   = s_valid && s_ready;

    assign conv_en  = accept;
    assign conv_act = s_data;
    assign conv_rst = (state == FLUSH);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    conv_pos_tracker #(.n(n), .k(k), .s(s)) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state == FLUSH),
        .adv       (accept),
        .win_valid (win_valid),
        .last_px   (last_px)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FLUSH;
            FLUSH:   state_nx = STREAM;
            STREAM:  if (accept && last_px) state_nx = DRAIN;
            DRAIN:   if (!pend && out_cnt == CW'(OO) && out_free) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_weight <= '0;
            conv_gamma  <= '0;
            conv_beta   <= '0;
        end else if (state == IDLE && start) begin
            conv_weight <= cfg_weight;
            conv_gamma  <= cfg_gamma;
            conv_beta   <= cfg_beta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 1'b0;
            out_cnt <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            if (state == FLUSH) begin
                pend    <= 1'b0;
                out_cnt <= '0;
            end else begin
                // A new window accept re-arms pend even in the cycle the old one is captured.
                if (accept && win_valid) pend <= 1'b1;
                else if (capture)        pend <= 1'b0;
                if (capture) out_cnt <= out_cnt + CW'(1);
            end
            if (capture) begin
                m_valid <= 1'b1;
                m_data  <= conv_out;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_sequencer.sv
// Directed bench for conv_stream_sequencer on a 5x5 frame, stride 1 and 2, with a stand-in convolver.
module tb_conv_stream_sequencer;

    localparam int N  = 16;
    localparam int NP = 5;
    localparam int K  = 3;
    localparam int WW = K * K * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [WW-1:0] cfg_weight = '0;
    logic [N-1:0]  cfg_gamma = '0;
    logic [N-1:0]  cfg_beta = '0;
    logic [N-1:0]  s_data = '0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b1;
    int            sel = 0;
    int            rmode = 0;

    always #5 clk = ~clk;

    // Instance 0 runs stride 1, instance 1 stride 2; only the selected one sees start/s_valid.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [N-1:0]  act, gam, bet, cout, mdat, acc;
        logic [WW-1:0] wt;
        logic          srdy, cen, crst, mval, bsy, dn;
        conv_stream_sequencer #(.N(N), .n(NP), .k(K), .s(g + 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start && sel == g),
            .cfg_weight(cfg_weight), .cfg_gamma(cfg_gamma), .cfg_beta(cfg_beta),
            .s_valid(s_valid && sel == g), .s_ready(srdy), .s_data(s_data),
            .conv_rst(crst), .conv_en(cen), .conv_act(act), .conv_weight(wt),
            .conv_gamma(gam), .conv_beta(bet), .conv_out(cout),
            .m_valid(mval), .m_ready(m_ready), .m_data(mdat), .busy(bsy), .done(dn)
        );
        // Stand-in convolver: result tagged with the most recently accepted pixel.
        always @(posedge clk) begin
            if (crst)     acc <= '0;
            else if (cen) acc <= act + gam + bet + wt[N-1:0];
        end
        assign cout = acc;
    end

    logic          sr, mv, dn, bsy, crst;
    logic [N-1:0]  md, cg, cb;
    logic [WW-1:0] cw;
    assign sr   = (sel == 1) ? g_dut[1].srdy : g_dut[0].srdy;
    assign mv   = (sel == 1) ? g_dut[1].mval : g_dut[0].mval;
    assign dn   = (sel == 1) ? g_dut[1].dn   : g_dut[0].dn;
    assign bsy  = (sel == 1) ? g_dut[1].bsy  : g_dut[0].bsy;
    assign crst = (sel == 1) ? g_dut[1].crst : g_dut[0].crst;
    assign md   = (sel == 1) ? g_dut[1].mdat : g_dut[0].mdat;
    assign cg   = (sel == 1) ? g_dut[1].gam  : g_dut[0].gam;
    assign cb   = (sel == 1) ? g_dut[1].bet  : g_dut[0].bet;
    assign cw   = (sel == 1) ? g_dut[1].wt   : g_dut[0].wt;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [N-1:0]  q[$];
    int            beats = 0, exp_total = 0, last_beat_cyc = -10, cyc = 0, flush_cnt = 0;
    bit            done_seen = 0, prev_hold = 0, prev_done = 0, stall_done = 0;
    int            stall_cnt = 0;
    logic [N-1:0]  prev_data = '0;
    logic [WW-1:0] exp_w = '0;
    logic [N-1:0]  exp_g = '0, exp_b = '0;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected output stream from the window rule applied to a raster of base+1..base+25.
    function automatic void build_q(input int st, input int base, input logic [N-1:0] off);
        q.delete();
        for (int r = 0; r < NP; r++)
            for (int c = 0; c < NP; c++)
                if (r >= K - 1 && c >= K - 1 && (r - (K - 1)) % st == 0 && (c - (K - 1)) % st == 0)
                    q.push_back(N'(base + r * NP + c + 1) + off);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_hold = 0;
            prev_done = 0;
        end else begin
            if (bsy) begin
                chk("cfg_weight_latched", cw, exp_w);
                chk("cfg_gamma_latched", WW'(cg), WW'(exp_g));
                chk("cfg_beta_latched", WW'(cb), WW'(exp_b));
            end
            if (prev_hold) begin
                chk("m_valid_hold", WW'(mv), WW'(1));
                chk("m_data_hold", WW'(md), WW'(prev_data));
            end
            if (mv && m_ready) begin
                if (q.size() == 0) chk("extra_beat", WW'(beats + 1), WW'(exp_total));
                else chk("m_data", WW'(md), WW'(q.pop_front()));
                beats++;
                last_beat_cyc = cyc;
            end
            prev_hold = mv && !m_ready;
            prev_data = md;
            if (crst) flush_cnt++;
            if (dn) begin
                chk("done_after_last_beat", WW'(cyc), WW'(last_beat_cyc + 1));
                chk("beats_at_done", WW'(beats), WW'(exp_total));
                chk("queue_empty_at_done", WW'(q.size()), '0);
                if (prev_done) chk("done_one_cycle", WW'(0), WW'(1));
                done_seen = 1;
            end
            prev_done = dn;
        end
    end

    // m_ready driver: 0 = always ready, 1 = random, 2 = 10-cycle stall after the first beat.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: begin
                if (stall_cnt > 0) begin
                    chk("stall_s_ready_low", WW'(sr), '0);
                    stall_cnt--;
                    m_ready = (stall_cnt == 0);
                end else begin
                    m_ready = 1'b1;
                    if (beats >= 1 && !stall_done) begin
                        stall_done = 1;
                        stall_cnt  = 10;
                        m_ready    = 1'b0;
                    end
                end
            end
        endcase
    end

    task automatic send_px(input logic [N-1:0] d, input bit gaps);
        int guard = 0;
        if (gaps) begin
            s_valid = 1'b0;
            while ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        forever begin
            @(negedge clk);
            if (sr) break;
            guard++;
            if (guard > 200) begin
                chk("s_ready_timeout", '0, WW'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_valid"}, WW'(mv), '0);
        chk({tag, "_m_data"}, WW'(md), '0);
        chk({tag, "_busy"}, WW'(bsy), '0);
        chk({tag, "_done"}, WW'(dn), '0);
        chk({tag, "_conv_rst"}, WW'(crst), '0);
        chk({tag, "_s_ready"}, WW'(sr), '0);
        chk({tag, "_conv_weight"}, cw, '0);
        chk({tag, "_conv_gamma"}, WW'(cg), '0);
    endtask

    task automatic run_frame(input int si, input int base, input bit gaps, input int mode,
                             input int abort_at, input bit poke_start);
        logic [N-1:0] off;
        int guard;
        sel = si;
        rmode = mode;
        stall_done = 0;
        for (int i = 0; i < K * K; i++) exp_w[i*N +: N] = N'($urandom);
        exp_g = N'($urandom_range(0, 255));
        exp_b = N'($urandom_range(0, 255));
        cfg_weight = exp_w;
        cfg_gamma  = exp_g;
        cfg_beta   = exp_b;
        off = exp_g + exp_b + exp_w[N-1:0];
        build_q(si + 1, base, off);
        exp_total = q.size();
        beats = 0;
        done_seen = 0;
        flush_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Config inputs change mid-frame; the latched copy must not follow.
        cfg_weight = ~cfg_weight;
        cfg_gamma  = ~cfg_gamma;
        cfg_beta   = cfg_beta + N'(1);
        for (int p = 0; p < NP * NP; p++) begin
            if (abort_at != 0 && p == abort_at) begin
                #1 rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(posedge clk);
                #3 rst_n = 1'b1;
                q.delete();
                @(posedge clk);
                #1;
                return;
            end
            if (poke_start && p == 10) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            send_px(N'(base + p + 1), gaps);
        end
        guard = 0;
        while (!done_seen && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("done_seen", WW'(done_seen), WW'(1));
        chk("flush_cycles", WW'(flush_cnt), WW'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Model pins: ramp 1..25 with zero offset.
        build_q(1, 0, '0);
        chk("model_s1_count", WW'(q.size()), WW'(9));
        chk("model_s1_first", WW'(q[0]), WW'(13));
        chk("model_s1_last", WW'(q[8]), WW'(25));
        build_q(2, 0, '0);
        chk("model_s2_count", WW'(q.size()), WW'(4));
        chk("model_s2_seq", WW'({q[0], q[1], q[2], q[3]}), WW'({16'd13, 16'd15, 16'd23, 16'd25}));
        q.delete();

        #3;
        check_reset_outputs("reset");
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_frame(0, 0, 0, 0, 0, 0);
        chk("s1_total_beats", WW'(beats), WW'(9));
        run_frame(1, 0, 0, 0, 0, 0);
        chk("s2_total_beats", WW'(beats), WW'(4));
        run_frame(0, 100, 0, 2, 0, 0);
        chk("stall_total_beats", WW'(beats), WW'(9));
        run_frame(0, 200, 1, 1, 0, 0);
        run_frame(1, 300, 1, 1, 0, 0);
        run_frame(0, 400, 0, 0, 0, 1);
        chk("poke_total_beats", WW'(beats), WW'(9));
        run_frame(0, 500, 0, 0, 12, 0);
        run_frame(0, 600, 0, 0, 0, 0);
        chk("restart_total_beats", WW'(beats), WW'(9));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
